wiring: RTL and testbench



---
 rtl/wiring.sv | 68 ++++++
 tb/tb_wiring.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wiring.sv
// Single-cycle 32-bit register-to-register datapath: 32x32 register file,
// 18-bit instruction decode, ALU, and a registered result output.
module wiring (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] instruct,
    output logic [31:0] muxout
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NAND = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SGT  = 3'b101,
        OP_SLL  = 3'b110,
        OP_SRL  = 3'b111
    } op_t;

    logic [31:0] regs [32];

    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;

    assign op = op_t'(instruct[17:15]);
    assign rd = instruct[14:10];
    assign rs = instruct[9:5];
    assign rt = instruct[4:0];

    // Operands come from the pre-edge register contents; bits[4:0] double as shamt.
    assign a = regs[rs];
    assign b = regs[rt];

    always_comb begin
        result = 32'd0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SGT:  result = (a > b) ? 32'd1 : 32'd0;
            OP_SLL:  result = a << rt;
            OP_SRL:  result = a >> rt;
            default: result = 32'd0;
        endcase
    end

    // Reset preloads R[k] = k so a fresh machine has distinct known operands.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= 32'(k);
            end
            muxout <= 32'd0;
        end else begin
            regs[rd] <= result;
            muxout   <= result;
        end
    end

endmodule

// File: tb/tb_wiring.sv
// Directed bench for wiring: table-driven instruction program plus
// hand-written reset and register-file corner sequences.
module tb_wiring;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] AND  = 3'b001;
    localparam logic [2:0] NAND = 3'b010;
    localparam logic [2:0] OR   = 3'b011;
    localparam logic [2:0] XOR  = 3'b100;
    localparam logic [2:0] SGT  = 3'b101;
    localparam logic [2:0] SLL  = 3'b110;
    localparam logic [2:0] SRL  = 3'b111;

    typedef struct {
        string       name;
        logic [17:0] instr;
        logic [31:0] exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [17:0] instruct;
    logic [31:0] muxout;

    int checks;
    int errors;
    vec_t vecs[$];

    wiring dut (
        .clock    (clock),
        .reset    (reset),
        .instruct (instruct),
        .muxout   (muxout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [17:0] enc(input logic [2:0] op, input int rd,
                                        input int rs, input int rt);
        return {op, 5'(rd), 5'(rs), 5'(rt)};
    endfunction

    task automatic add_vec(input string name, input logic [2:0] op, input int rd,
                           input int rs, input int rt, input logic [31:0] exp);
        vec_t v;
        v.name  = name;
        v.instr = enc(op, rd, rs, rt);
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (muxout !== exp) begin
            errors++;
            $display("FAIL %s: muxout=%08h expected=%08h", name, muxout, exp);
        end
    endtask

    // Present inputs on the falling edge, execute on the rising edge, sample 1ns later.
    task automatic step(input logic rst, input logic [17:0] instr);
        @(negedge clock);
        reset    = rst;
        instruct = instr;
        @(posedge clock);
        #1;
    endtask

    task automatic exec(input string name, input logic [17:0] instr,
                        input logic [31:0] exp);
        step(1'b0, instr);
        check(name, exp);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        instruct = '0;

        add_vec("nand_r3",     NAND,  3,  1,  2, 32'hFFFF_FFFF);
        add_vec("srl_r4_28",   SRL,   4,  3, 28, 32'h0000_000F);
        add_vec("srl_r5_1",    SRL,   5,  4,  1, 32'h0000_0007);
        add_vec("xor_r1",      XOR,   1,  4,  5, 32'h0000_0008);
        add_vec("sll_r2_1",    SLL,   2,  5,  1, 32'h0000_000E);
        add_vec("or_r6",       OR,    6,  1,  2, 32'h0000_000E);
        add_vec("add_r7",      ADD,   7,  4,  6, 32'h0000_001D);
        add_vec("sgt_r8",      SGT,   8,  4,  6, 32'h0000_0001);
        add_vec("and_r9",      AND,   9,  6,  8, 32'h0000_0000);
        add_vec("add_wrap",    ADD,  12,  3,  1, 32'h0000_0007);
        add_vec("sgt_equal",   SGT,  13,  4,  4, 32'h0000_0000);
        add_vec("sgt_unsigned",SGT,  14,  3,  4, 32'h0000_0001);
        add_vec("sgt_less",    SGT,  15,  4,  3, 32'h0000_0000);
        add_vec("sll_0",       SLL,  16,  3,  0, 32'hFFFF_FFFF);
        add_vec("sll_31",      SLL,  17,  3, 31, 32'h8000_0000);
        add_vec("srl_31",      SRL,  18,  3, 31, 32'h0000_0001);
        add_vec("self_add_1",  ADD,   5,  5,  5, 32'h0000_000E);
        add_vec("self_add_2",  ADD,   5,  5,  5, 32'h0000_001C);
        add_vec("readback_r5", OR,   19,  5,  5, 32'h0000_001C);
        add_vec("readback_r17",OR,   20, 17, 17, 32'h8000_0000);
        add_vec("write_r0",    ADD,   0,  1,  1, 32'h0000_0010);
        add_vec("readback_r0", OR,   21,  0,  0, 32'h0000_0010);

        // Reset state
        step(1'b1, enc(ADD, 1, 3, 3));
        step(1'b1, '0);
        check("reset_muxout", 32'h0000_0000);

        foreach (vecs[i]) begin
            exec(vecs[i].name, vecs[i].instr, vecs[i].exp);
        end

        // Register-file reset values
        step(1'b1, '0);
        check("reset2_muxout", 32'h0000_0000);
        exec("reset_r31", enc(OR, 10, 31, 31), 32'h0000_001F);
        exec("reset_r0",  enc(OR, 11, 0, 0),   32'h0000_0000);
        exec("reset_r1r2",enc(ADD, 22, 1, 2), 32'h0000_0003);

        // Mid-sequence reset: the ADD on instruct must have no effect
        exec("pre_reset_add", enc(ADD, 1, 1, 1), 32'h0000_0002);
        step(1'b1, enc(ADD, 1, 30, 30));
        check("midreset_muxout", 32'h0000_0000);
        exec("midreset_r1", enc(OR, 23, 1, 1), 32'h0000_0001);
        exec("midreset_r30", enc(OR, 24, 30, 30), 32'h0000_001E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
